vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator that succeeds the fixed 640x480 controller.
- Produces HSYNC, VSYNC, blank and pixel coordinates for any mode described by its parameters.
- Adds configurable sync polarity, a run enable, line/frame start strobes, and a coordinate lookahead so pixel sources with pipeline latency line up with sync and blank.
- Sits between the pixel clock domain root and the frame/pattern generators feeding the DAC.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (cycles)
- H_SYNC, 96, horizontal sync width (cycles)
- H_BACK, 48, horizontal back porch (cycles)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HS_POL, 0, active level of hs (0 = active-low)
- VS_POL, 0, active level of vs (0 = active-low)
- PIX_LAT, 0, cycles by which coordinates lead hs/vs/blank_n (0..15)
- XW, 11, coord_x width; must hold H_ACTIVE
- YW, 10, coord_y width; must hold V_ACTIVE

Ports:
- vga_clk, input, 1, pixel clock; all logic on the rising edge
- reset_n, input, 1, asynchronous active-low reset
- en, input, 1, run enable; 0 freezes the raster
- hs, output, 1, horizontal sync at HS_POL
- vs, output, 1, vertical sync at VS_POL
- BLANK_n, output, 1, 1 = active video
- coord_x, output, XW, active pixel column, or H_ACTIVE when not visible
- coord_y, output, YW, active line, or V_ACTIVE when not visible
- coord_valid, output, 1, coordinates inside the active area
- line_start, output, 1, one-cycle strobe at h_cnt==0
- frame_start, output, 1, one-cycle strobe at h_cnt==0 and v_cnt==0

Behaviour:
- Totals: H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT; V_TOTAL = V_SYNC+V_BACK+V_ACTIVE+V_FRONT.
- Counters h_cnt run 0..H_TOTAL-1 and v_cnt run 0..V_TOTAL-1.
  - h_cnt wraps to 0 at H_TOTAL-1. v_cnt increments only on that wrap and wraps to 0 at V_TOTAL-1.
- Region order per axis: sync, back porch, active, front porch.
  - Horizontal active window: H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_ACTIVE.
  - Vertical active window defined identically.
- Sync asserted while h_cnt < H_SYNC (v_cnt < V_SYNC for vs).
- Coordinates in the active window: coord_x = h_cnt-(H_SYNC+H_BACK) and coord_y = v_cnt-(V_SYNC+V_BACK). coord_valid = horizontal active AND vertical active.
- Out of window, coord_x holds H_ACTIVE and coord_y holds V_ACTIVE. Each axis is judged independently.
- Latency:
  - coord_x, coord_y, coord_valid, line_start and frame_start are registered, 1 cycle after the counter state.
  - hs, vs and BLANK_n pass through PIX_LAT further register stages, so they appear 1+PIX_LAT cycles after the counter state.
  - With PIX_LAT=0, all outputs are aligned.
- en=0: counters and every pipeline stage hold their values, and strobes are forced to 0. Operation resumes from the held state on en=1 with no skipped counts.
- Reset (asynchronous, any time, including mid-frame):
  - counters = 0
  - coord_x = H_ACTIVE, coord_y = V_ACTIVE
  - coord_valid = 0, line_start = 0, frame_start = 0
  - every hs/vs/BLANK_n stage holds the inactive level: hs = ~HS_POL, vs = ~VS_POL, BLANK_n = 0
- After reset release with en=1:
  - The first edge registers counter state (0,0): frame_start=1 and line_start=1 at 1 cycle.
  - hs and vs go active at 1+PIX_LAT cycles.
- Reset releases synchronously into the counter logic. No partial first line.
- Parameters are elaboration-time only. Any parameter set with H_TOTAL > 2^12 or PIX_LAT > 15 is rejected with a $error at elaboration.

Optional Feature:
- Macro VGA_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt [15:0]. It is reset to 0 and increments, wrapping 0xFFFF->0, in the same cycle frame_start is registered high.
  - It holds while en=0.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
- Defaults, en=1 from reset:
  - hs low for 96 of every 800 cycles.
  - BLANK_n high for exactly 640 consecutive cycles per visible line.
  - vs low for 2 lines = 1600 cycles.
  - frame_start period is 420000 cycles.
- Defaults, first active pixel: coord_x=0, coord_y=0, coord_valid=1 exactly 1 cycle after h_cnt=144, v_cnt=35. The last active pixel reads coord_x=639, coord_y=479.
- PIX_LAT=3: the BLANK_n rising edge lags the coord_valid rising edge by exactly 3 cycles on every line. hs/vs lag line_start/frame_start by 3.
- HS_POL=1, VS_POL=1, reset asserted mid-line: hs=0, vs=0, BLANK_n=0, coord_x=640, coord_y=480 immediately (asynchronous). After release, frame_start pulses at cycle 1.
- en deasserted for 50 cycles at coord_x=100: all outputs frozen, no strobes. After re-enable, coord_x continues 101, 102, and the frame period is extended by exactly 50 cycles.
- With VGA_FRAME_CNT_EN: frame_cnt reads 0,1,2 across three frames. Forcing 65535 frames, or preloading via hierarchical force, wraps it to 0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised VGA raster timing generator. A horizontal/vertical counter
//   pair walks the raster in the order sync, back porch, active, front porch.
//   Pixel coordinates and the line/frame strobes are registered one cycle
//   after the counter state. hs/vs/BLANK_n pass through PIX_LAT further
//   stages, so a pixel source with PIX_LAT cycles of latency lines up with
//   them.
//
// Ports
//   vga_clk     in   pixel clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   en          in   run enable; 0 freezes counters and every pipeline stage
//   hs, vs      out  sync outputs, active level HS_POL / VS_POL
//   BLANK_n     out  1 = active video
//   coord_x     out  active column, H_ACTIVE when horizontally outside
//   coord_y     out  active line, V_ACTIVE when vertically outside
//   coord_valid out  both axes inside the active window
//   line_start  out  one-cycle strobe for h_cnt==0
//   frame_start out  one-cycle strobe for h_cnt==0 and v_cnt==0
//   frame_cnt   out  16-bit frame counter (only with VGA_FRAME_CNT_EN)
//
// Optional feature macro: VGA_FRAME_CNT_EN
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int PIX_LAT  = 0,
  parameter int XW       = 11,
  parameter int YW       = 10
) (
  input  logic          vga_clk,
  input  logic          reset_n,
  input  logic          en,
  output logic          hs,
  output logic          vs,
  output logic          BLANK_n,
  output logic [XW-1:0] coord_x,
  output logic [YW-1:0] coord_y,
  output logic          coord_valid,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int H_START = H_SYNC + H_BACK;
  localparam int H_END   = H_START + H_ACTIVE;
  localparam int V_START = V_SYNC + V_BACK;
  localparam int V_END   = V_START + V_ACTIVE;
  localparam int HCW     = 12;
  localparam int VCW     = (V_TOTAL > 2) ? $clog2(V_TOTAL) : 1;
  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  if (H_TOTAL > 4096 || PIX_LAT > 15 || PIX_LAT < 0) begin : g_bad_params
    $error("vga_timing_gen: H_TOTAL must be <= 4096 and PIX_LAT within 0..15");
  end

  logic [HCW-1:0]     r_h_cnt;
  logic [VCW-1:0]     r_v_cnt;
  logic [31:0]        w_h_pos;
  logic [31:0]        w_v_pos;
  logic               w_h_last;
  logic               w_v_last;
  logic               w_h_act;
  logic               w_v_act;
  logic               w_hs;
  logic               w_vs;
  logic [XW-1:0]      w_x;
  logic [YW-1:0]      w_y;
  logic [XW-1:0]      r_coord_x;
  logic [YW-1:0]      r_coord_y;
  logic               r_coord_valid;
  logic               r_line_start;
  logic               r_frame_start;
  logic [PIX_LAT:0]   r_hs_pipe;
  logic [PIX_LAT:0]   r_vs_pipe;
  logic [PIX_LAT:0]   r_blank_pipe;

  // Region decode is done in 32 bits so an active window ending exactly at
  // the counter's range limit cannot wrap.
  assign w_h_pos  = 32'(r_h_cnt);
  assign w_v_pos  = 32'(r_v_cnt);
  assign w_h_last = (w_h_pos == 32'(H_TOTAL - 1));
  assign w_v_last = (w_v_pos == 32'(V_TOTAL - 1));
  assign w_h_act  = (w_h_pos >= 32'(H_START)) && (w_h_pos < 32'(H_END));
  assign w_v_act  = (w_v_pos >= 32'(V_START)) && (w_v_pos < 32'(V_END));
  assign w_hs     = (w_h_pos < 32'(H_SYNC)) ? HS_ON : ~HS_ON;
  assign w_vs     = (w_v_pos < 32'(V_SYNC)) ? VS_ON : ~VS_ON;
  assign w_x      = w_h_act ? XW'(w_h_pos - 32'(H_START)) : XW'(H_ACTIVE);
  assign w_y      = w_v_act ? YW'(w_v_pos - 32'(V_START)) : YW'(V_ACTIVE);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (en) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
    end
  end

  // First output stage plus the extra sync/blank delay line; all stages
  // freeze together with the counters.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_coord_x     <= XW'(H_ACTIVE);
      r_coord_y     <= YW'(V_ACTIVE);
      r_coord_valid <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_hs_pipe     <= {(PIX_LAT+1){~HS_ON}};
      r_vs_pipe     <= {(PIX_LAT+1){~VS_ON}};
      r_blank_pipe  <= '0;
    end else if (en) begin
      r_coord_x       <= w_x;
      r_coord_y       <= w_y;
      r_coord_valid   <= w_h_act && w_v_act;
      r_line_start    <= (r_h_cnt == '0);
      r_frame_start   <= (r_h_cnt == '0) && (r_v_cnt == '0);
      r_hs_pipe[0]    <= w_hs;
      r_vs_pipe[0]    <= w_vs;
      r_blank_pipe[0] <= w_h_act && w_v_act;
      for (int i = 1; i <= PIX_LAT; i++) begin
        r_hs_pipe[i]    <= r_hs_pipe[i-1];
        r_vs_pipe[i]    <= r_vs_pipe[i-1];
        r_blank_pipe[i] <= r_blank_pipe[i-1];
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Counts on the same edge that loads a high frame_start.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_cnt <= '0;
    end else if (en && (r_h_cnt == '0) && (r_v_cnt == '0)) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

  // Held strobes must not repeat while the raster is frozen.
  assign line_start  = r_line_start & en;
  assign frame_start = r_frame_start & en;
  assign coord_x     = r_coord_x;
  assign coord_y     = r_coord_y;
  assign coord_valid = r_coord_valid;
  assign hs          = r_hs_pipe[PIX_LAT];
  assign vs          = r_vs_pipe[PIX_LAT];
  assign BLANK_n     = r_blank_pipe[PIX_LAT];

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Self-checking bench for vga_timing_gen in a small raster (28 x 13
//   cycles/lines) so several whole frames fit in a short run. The reference
//   model derives every output from the number of enabled clock edges since
//   reset using plain arithmetic over the frame position.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int HA  = 16;
  localparam int HF  = 3;
  localparam int HSY = 4;
  localparam int HB  = 5;
  localparam int VA  = 6;
  localparam int VF  = 2;
  localparam int VSY = 2;
  localparam int VB  = 3;
  localparam int PL  = 2;
  localparam bit HP  = 1'b1;
  localparam bit VP  = 1'b0;
  localparam int HT  = HSY + HB + HA + HF;
  localparam int VT  = VSY + VB + VA + VF;
  localparam int FT  = HT * VT;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        bl;
    logic [10:0] x;
    logic [9:0]  y;
    logic        val;
    logic        ls;
    logic        fs;
  } outs_t;

  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic        hs, vs, BLANK_n, coord_valid, line_start, frame_start;
  logic [10:0] coord_x;
  logic [9:0]  coord_y;
  outs_t       act;
  outs_t       exp_o;

  int vectors = 0;
  int miscompares = 0;
  int ne = 0;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
    .HS_POL(1), .VS_POL(0), .PIX_LAT(PL), .XW(11), .YW(10)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .en(en),
    .hs(hs), .vs(vs), .BLANK_n(BLANK_n),
    .coord_x(coord_x), .coord_y(coord_y), .coord_valid(coord_valid),
    .line_start(line_start), .frame_start(frame_start)
  );

  always #5 vga_clk = ~vga_clk;

  assign act = {hs, vs, BLANK_n, coord_x, coord_y, coord_valid, line_start, frame_start};

  // Expected outputs after n enabled edges since reset. Edge k registers
  // frame position k-1; sync/blank show the position PL edges older.
  function automatic outs_t model(input int n, input bit en_now);
    outs_t o;
    int p, h, v, q;
    o.hs = ~HP; o.vs = ~VP; o.bl = 1'b0;
    o.x = 11'(HA); o.y = 10'(VA); o.val = 1'b0; o.ls = 1'b0; o.fs = 1'b0;
    if (n > 0) begin
      p = (n - 1) % FT; h = p % HT; v = p / HT;
      if (h >= HSY + HB && h < HSY + HB + HA) o.x = 11'(h - HSY - HB);
      if (v >= VSY + VB && v < VSY + VB + VA) o.y = 10'(v - VSY - VB);
      o.val = (o.x != 11'(HA)) && (o.y != 10'(VA));
      o.ls  = en_now && (h == 0);
      o.fs  = en_now && (p == 0);
    end
    q = n - 1 - PL;
    if (q >= 0) begin
      p = q % FT; h = p % HT; v = p / HT;
      o.hs = (h < HSY) ? HP : ~HP;
      o.vs = (v < VSY) ? VP : ~VP;
      o.bl = (h >= HSY + HB && h < HSY + HB + HA) && (v >= VSY + VB && v < VSY + VB + VA);
    end
    return o;
  endfunction

  task automatic applyStimulus(input bit e);
    en = e;
    @(posedge vga_clk);
    if (e && reset_n) ne++;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ne = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1);
      exp_o = model(0, 1'b1);
      vectors++;
      if (act !== exp_o) begin
        miscompares++;
        $display("[TB] FAIL reset_state cyc=%0d actual=%h required=%h", i, act, exp_o);
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_full_frame();
    int blank_cycles = 0;
    for (int i = 0; i < FT + 2 * HT; i++) begin
      applyStimulus(1'b1);
      exp_o = model(ne, 1'b1);
      vectors++;
      if (act !== exp_o) begin
        miscompares++;
        $display("[TB] FAIL full_frame ne=%0d actual=%h required=%h", ne, act, exp_o);
      end
      if (i >= PL && i < FT + PL && BLANK_n === 1'b1) blank_cycles++;
    end
    vectors++;
    if (blank_cycles !== HA * VA) begin
      miscompares++;
      $display("[TB] FAIL blank_count actual=%0d required=%0d", blank_cycles, HA * VA);
    end
  endtask

  task automatic test_pix_lat();
    int vq[$];
    int lq[$];
    int t;
    logic pv = coord_valid;
    logic pb = BLANK_n;
    logic ph = hs;
    for (int i = 0; i < FT; i++) begin
      applyStimulus(1'b1);
      if (coord_valid === 1'b1 && pv !== 1'b1) vq.push_back(i);
      if (line_start === 1'b1) lq.push_back(i);
      if (BLANK_n === 1'b1 && pb !== 1'b1 && vq.size() > 0) begin
        t = vq.pop_front();
        vectors++;
        if (i - t !== PL) begin
          miscompares++;
          $display("[TB] FAIL blank_lag actual=%0d required=%0d", i - t, PL);
        end
      end
      if (hs === HP && ph !== HP && lq.size() > 0) begin
        t = lq.pop_front();
        vectors++;
        if (i - t !== PL) begin
          miscompares++;
          $display("[TB] FAIL hs_lag actual=%0d required=%0d", i - t, PL);
        end
      end
      pv = coord_valid; pb = BLANK_n; ph = hs;
    end
  endtask

  task automatic test_enable_freeze();
    int guard = 0;
    while (!(coord_valid === 1'b1 && coord_x === 11'd5) && guard < FT + 4) begin
      applyStimulus(1'b1);
      guard++;
    end
    vectors++;
    if (guard >= FT + 4) begin
      miscompares++;
      $display("[TB] FAIL freeze_search actual=timeout required=coord_x_5");
    end
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b0);
      exp_o = model(ne, 1'b0);
      vectors++;
      if (act !== exp_o) begin
        miscompares++;
        $display("[TB] FAIL enable_freeze cyc=%0d actual=%h required=%h", i, act, exp_o);
      end
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1);
      exp_o = model(ne, 1'b1);
      vectors++;
      if (act !== exp_o) begin
        miscompares++;
        $display("[TB] FAIL enable_resume cyc=%0d actual=%h required=%h", i, act, exp_o);
      end
    end
  endtask

  task automatic test_random_enable();
    bit e;
    for (int i = 0; i < 3 * FT; i++) begin
      e = ($urandom_range(0, 3) != 0);
      applyStimulus(e);
      exp_o = model(ne, e);
      vectors++;
      if (act !== exp_o) begin
        miscompares++;
        $display("[TB] FAIL random_enable ne=%0d en=%0d actual=%h required=%h", ne, e, act, exp_o);
      end
    end
  endtask

  task automatic test_reset_midline();
    for (int i = 0; i < HT + 7; i++) applyStimulus(1'b1);
    #2;
    reset_n = 1'b0;
    ne = 0;
    #1;
    exp_o = model(0, 1'b1);
    vectors++;
    if (act !== exp_o) begin
      miscompares++;
      $display("[TB] FAIL async_reset actual=%h required=%h", act, exp_o);
    end
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    reset_n = 1'b1;
    for (int i = 0; i < 2 * HT; i++) begin
      applyStimulus(1'b1);
      exp_o = model(ne, 1'b1);
      vectors++;
      if (act !== exp_o) begin
        miscompares++;
        $display("[TB] FAIL post_reset ne=%0d actual=%h required=%h", ne, act, exp_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_pix_lat();
    test_enable_freeze();
    test_random_enable();
    test_reset_midline();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
